// File: rtl/usr_ctrl.sv
// Command sequencer driving a 4-bit universal shift register.
// Define USR_CTRL_ROTATE_EN to support ROL/ROR; otherwise they are illegal.
module usr_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic [3:0]       cmd_data,
  output logic [1:0]       usr_sel,
  output logic [3:0]       usr_pin,
  output logic             usr_lsi,
  output logic             usr_rsi,
  input  logic [3:0]       usr_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       result
);

  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_RGT  = 2'b01;
  localparam logic [1:0] SEL_LFT  = 2'b10;
  localparam logic [1:0] SEL_LD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fill_q;
  logic [3:0]       data_q;
  logic             err_q;
  logic [3:0]       res_q;

  logic acc;
  logic dec_ld;
  logic dec_sh;
  logic dec_ill;
  logic zero;
  logic rot_ok;

`ifdef USR_CTRL_ROTATE_EN
  assign rot_ok = (cmd_op == OP_ROL) || (cmd_op == OP_ROR);
`else
  assign rot_ok = 1'b0;
`endif

  assign acc     = cmd_valid && (state == S_IDLE);
  assign dec_ld  = (cmd_op == OP_LD);
  assign dec_sh  = (cmd_op == OP_SHL) || (cmd_op == OP_SHR) || rot_ok;
  assign dec_ill = !dec_ld && !dec_sh;
  assign zero    = (cmd_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      cnt_q  <= '0;
      fill_q <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        op_q   <= cmd_op;
        cnt_q  <= cmd_cnt;
        fill_q <= cmd_fill;
        data_q <= cmd_data;
        err_q  <= dec_ill;
      end else if (state == S_SHIFT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state == S_DONE) res_q <= usr_q;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (acc) begin
          unique case (1'b1)
            dec_ill:          nxt = S_DONE;
            dec_ld:           nxt = S_LOAD;
            dec_sh && zero:   nxt = S_DONE;
            dec_sh && !zero:  nxt = S_SHIFT;
            default:          nxt = S_DONE;
          endcase
        end
      end
      S_LOAD:  nxt = S_DONE;
      S_SHIFT: if (cnt_q == CNT_W'(1)) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    usr_sel   = SEL_HOLD;
    usr_pin   = '0;
    usr_lsi   = 1'b0;
    usr_rsi   = 1'b0;
    result    = res_q;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: begin
        usr_sel = SEL_LD;
        usr_pin = data_q;
      end
      S_SHIFT: begin
        unique case (op_q)
          OP_SHL: begin
            usr_sel = SEL_LFT;
            usr_lsi = fill_q;
          end
          OP_SHR: begin
            usr_sel = SEL_RGT;
            usr_rsi = fill_q;
          end
`ifdef USR_CTRL_ROTATE_EN
          OP_ROL: begin
            usr_sel = SEL_LFT;
            usr_lsi = usr_q[3];
          end
          OP_ROR: begin
            usr_sel = SEL_RGT;
            usr_rsi = usr_q[0];
          end
`endif
          default: usr_sel = SEL_HOLD;
        endcase
      end
      S_DONE: begin
        // USR has taken its last step by now, so expose it directly
        done   = 1'b1;
        err    = err_q;
        result = usr_q;
      end
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_usr_ctrl.sv
// Bench for usr_ctrl: behavioural USR plant plus arithmetic reference model.
// Directed test-plan steps followed by randomized commands.
module tb_usr_ctrl;

  localparam int CNT_W = 3;

`ifdef USR_CTRL_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_fill;
  logic [3:0]       cmd_data;
  logic [1:0]       usr_sel;
  logic [3:0]       usr_pin;
  logic             usr_lsi;
  logic             usr_rsi;
  logic [3:0]       usr_q;
  logic             busy;
  logic             done;
  logic             err;
  logic [3:0]       result;

  int         nvec = 0;
  int         nerr = 0;
  logic [3:0] mq = 4'h0;

  always #5 clk = ~clk;

  usr_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_fill  (cmd_fill),
    .cmd_data  (cmd_data),
    .usr_sel   (usr_sel),
    .usr_pin   (usr_pin),
    .usr_lsi   (usr_lsi),
    .usr_rsi   (usr_rsi),
    .usr_q     (usr_q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  // USR plant sharing clk/rst with the controller
  always_ff @(posedge clk) begin
    if (rst) usr_q <= 4'h0;
    else begin
      case (usr_sel)
        2'b11:   usr_q <= usr_pin;
        2'b10:   usr_q <= {usr_q[2:0], usr_lsi};
        2'b01:   usr_q <= {usr_rsi, usr_q[3:1]};
        default: usr_q <= usr_q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  function automatic logic [3:0] ref_res(input logic [2:0] op,
                                         input int n, input logic f,
                                         input logic [3:0] d,
                                         input logic [3:0] q);
    int v;
    int r;
    v = int'(q);
    r = n % 4;
    case (op)
      3'd0:    return d;
      3'd1:    return 4'(((v << n) | (f ? ((1 << n) - 1) : 0)) & 15);
      3'd2:    return 4'(((v | (f ? (((1 << n) - 1) << 4) : 0)) >> n) & 15);
      3'd3:    return 4'(((v << r) | (v >> (4 - r))) & 15);
      3'd4:    return 4'(((v >> r) | (v << (4 - r))) & 15);
      default: return q;
    endcase
  endfunction

  task automatic cmd(input logic [2:0] op, input logic [2:0] cnt,
                     input logic fill, input logic [3:0] d);
    logic [3:0] er;
    logic       ok;
    logic [1:0] es;
    int         el;
    int         lat;
    int         act;
    bit         got;
    ok = (op <= 3'd2) || (ROT_EN && op <= 3'd4);
    er = ok ? ref_res(op, int'(cnt), fill, d, mq) : mq;
    el = !ok ? 1 : (op == 3'd0) ? 2 : (cnt == 3'd0) ? 1 : int'(cnt) + 1;
    es = (op == 3'd0) ? 2'b11 :
         (op == 3'd1 || op == 3'd3) ? 2'b10 : 2'b01;
    @(negedge clk);
    chk("ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_fill  = fill;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_cnt   = 3'($urandom);
    cmd_fill  = 1'($urandom);
    cmd_data  = 4'($urandom);
    lat = 0;
    act = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
      else begin
        chk("busy", busy, 1);
        chk("ready_low", cmd_ready, 0);
        if (usr_sel != 2'b00) begin
          act++;
          chk("sel", usr_sel, es);
        end
      end
    end
    chk("done_seen", got, 1);
    chk("latency", lat, el);
    chk("active", act, el - 1);
    chk("sel_done", usr_sel, 0);
    chk("result", result, er);
    chk("err", err, !ok);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("hold", result, er);
    chk("ready_back", cmd_ready, 1);
    mq = er;
  endtask

  initial begin
    logic [3:0] bq[$];
    logic [3:0] eq[$];
    int         nacc;
    int         ndn;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_cnt   = '0;
    cmd_fill  = 1'b0;
    cmd_data  = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_sel", usr_sel, 0);
    chk("rst_pin", usr_pin, 0);
    chk("rst_lsi", usr_lsi, 0);
    chk("rst_rsi", usr_rsi, 0);
    rst = 1'b0;

    cmd(3'd0, 3'd0, 1'b0, 4'b1011);
    cmd(3'd1, 3'd2, 1'b1, 4'h0);
    cmd(3'd2, 3'd3, 1'b0, 4'h0);
    cmd(3'd0, 3'd0, 1'b0, 4'b1000);
    cmd(3'd3, 3'd1, 1'b0, 4'h0);
    cmd(3'd0, 3'd0, 1'b0, 4'b0110);
    cmd(3'd4, 3'd5, 1'b0, 4'h0);
    cmd(3'd1, 3'd0, 1'b1, 4'h0);
    cmd(3'd7, 3'd3, 1'b1, 4'hF);
    cmd(3'd2, 3'd7, 1'b1, 4'h0);

    bq   = '{4'h5, 4'hA, 4'h3};
    nacc = 0;
    ndn  = 0;
    cmd_op = 3'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        ndn++;
        if (eq.size() == 0) chk("b2b_extra", 1, 0);
        else chk("b2b_result", result, eq.pop_front());
      end
      if (busy) chk("b2b_ready", cmd_ready, 0);
      cmd_valid = (bq.size() > 0);
      if (bq.size() > 0) cmd_data = bq[0];
      if (cmd_valid && cmd_ready) begin
        eq.push_back(bq.pop_front());
        nacc++;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", nacc, 3);
    chk("b2b_dones", ndn, 3);
    mq = 4'h3;

    cmd(3'd0, 3'd0, 1'b0, 4'b1011);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_cnt   = 3'd7;
    cmd_fill  = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sel", usr_sel, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    chk("abort_q", usr_q, 0);
    rst = 1'b0;
    mq  = 4'h0;
    cmd(3'd0, 3'd0, 1'b0, 4'b0110);

    for (int i = 0; i < 40; i++) begin
      cmd(3'($urandom), 3'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/usr_ctrl.md
# usr_ctrl

Command sequencer for the 4-bit universal shift register (USR) datapath. It accepts one shift/load command at a time over a valid/ready handshake. It drives the USR mode select, parallel input and serial fill inputs cycle by cycle for the requested number of positions, then returns the final register value with a one-cycle done pulse. It sits between the bus-side command source and the USR instance; the USR shares `clk` and `rst` with this block.

## Interface
Parameters:
- `CNT_W`, default 3: width of shift-count field; max shift per command is 2^CNT_W−1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 3: 000 LOAD, 001 SHL, 010 SHR, 011 ROL, 100 ROR, others illegal.
- `cmd_cnt` in CNT_W: positions to shift or rotate; ignored for LOAD.
- `cmd_fill` in 1: serial fill bit for SHL/SHR.
- `cmd_data` in 4: load word for LOAD.
- `usr_sel` out 2: to USR `sel` (00 hold, 01 right, 10 left, 11 load).
- `usr_pin` out 4: to USR parallel input.
- `usr_lsi` out 1: to USR left-shift serial input (enters bit 0).
- `usr_rsi` out 1: to USR right-shift serial input (enters bit 3).
- `usr_q` in 4: USR output.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse with `done` for an illegal or disabled op.
- `result` out 4: `usr_q` sampled at `done`; held until the next `done`.

## Operation
- States:
  - IDLE: `cmd_ready`=1, `busy`=0, `usr_sel`=00.
  - LOAD: `usr_sel`=11, `usr_pin`=latched data.
  - SHIFT: `usr_sel`=10 for SHL/ROL and 01 for SHR/ROR; the remaining-count register decrements each cycle.
  - DONE: `usr_sel`=00, `done`=1, `busy`=1.
- All command fields are latched on acceptance (`cmd_valid & cmd_ready` at a rising edge). Inputs are ignored outside IDLE.
- State transitions:
  - IDLE → LOAD for LOAD.
  - IDLE → SHIFT for shift/rotate ops with count ≥ 1.
  - IDLE → DONE for count = 0 or an illegal op.
  - LOAD → DONE after 1 cycle.
  - SHIFT → DONE when the remaining count is 1.
  - DONE → IDLE always.
- Fill sources:
  - SHL: `usr_lsi` = latched fill.
  - SHR: `usr_rsi` = latched fill.
  - ROL: `usr_lsi` = `usr_q[3]`, combinational.
  - ROR: `usr_rsi` = `usr_q[0]`, combinational.
  - Unused serial input is driven 0.
- Illegal op: no USR mode other than 00 is ever driven; `err`=1 with `done`; `result` = current `usr_q`.
- `usr_pin` = latched data in LOAD and 0 in all other states.
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, `result`=0000, `usr_sel`=00, `usr_pin`=0000, `usr_lsi`=0, `usr_rsi`=0, count=0.
- Reset mid-command aborts the command. No `done` is issued, and the USR clears via its own reset.

## Timing
- Accept edge E. The first USR-affecting cycle is E+1, and the USR updates at the end of each active cycle.
- Latency from accept edge to `done` high:
  - LOAD: 2 cycles.
  - Shift/rotate by N ≥ 1: N+1 cycles.
  - Count 0 or illegal: 1 cycle.
- Back-to-back: `cmd_ready` drops the cycle after acceptance and returns the cycle after `done`. Peak throughput is one LOAD per 3 cycles.
- `result` updates at the same edge `done` rises and reflects all shifts of the command.
- `cmd_ready` does not depend combinationally on `cmd_valid`.

## Configuration
- `USR_CTRL_ROTATE_EN`:
  - Defined: ROL/ROR are supported as above.
  - Undefined: ops 011/100 are treated as illegal (IDLE → DONE, `err`=1, USR untouched), and the `usr_q`→serial-input feedback logic is removed.

## Test plan
- Reset, then LOAD 1011 → `usr_sel`=11 for 1 cycle; `done` 2 cycles after accept; `result`=1011; `err`=0.
- LOAD 1011, then SHL cnt=2 fill=1 → two cycles of `usr_sel`=10; `result`=1111. Then SHR cnt=3 fill=0 → `result`=0001.
- LOAD 1000, then ROL cnt=1 → `result`=0001. ROR cnt=5 from 0110 → `result`=0011. With macro undefined, both produce `err`=1 and `usr_q` is unchanged.
- SHL cnt=0 → `done` 1 cycle after accept, `usr_sel` stays 00, `result`=unchanged `usr_q`. Op 111 → `done`+`err`, no USR change.
- Hold `cmd_valid` high with 3 queued commands → exactly one accepted per IDLE visit; `cmd_ready`=0 while `busy`; no command lost or duplicated.
- Assert `rst` during the 3rd cycle of SHR cnt=7 → next cycle: IDLE, `usr_sel`=00, `result`=0000, no `done`; a new LOAD works normally.
